// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared HUB75 frame-buffer constants, address layout and read-out states
package hub75_pkg;

  localparam int DEF_N_BANKS  = 2;
  localparam int DEF_N_ROWS   = 32;
  localparam int DEF_N_COLS   = 64;
  localparam int DEF_BITDEPTH = 24;
  localparam int DEF_FB_AW    = 13;
  localparam int DEF_FB_DW    = 16;
  localparam int DEF_FB_DC    = 2;

  localparam int CS = $clog2(DEF_FB_DC);
  localparam int CW = $clog2(DEF_N_COLS) + $clog2(DEF_N_BANKS) + CS;

  // FB address, LSB first: dc, bank, col, row (same layout as the write-in side)
  localparam int FB_DC_LSB   = 0;
  localparam int FB_BANK_LSB = CS;
  localparam int FB_COL_LSB  = CS + $clog2(DEF_N_BANKS);
  localparam int FB_ROW_LSB  = CW;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_RUN
  } rd_state_e;

endpackage

// File: rtl/hub75_linebuffer.sv
// rtl/hub75_linebuffer.sv - multi-word line buffer, per-word write mask, registered read
module hub75_linebuffer #(
  parameter int N_WORDS    = 2,
  parameter int WORD_WIDTH = 24,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [N_WORDS-1:0]            wr_mask,
  input  logic [WORD_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [N_WORDS*WORD_WIDTH-1:0] rd_data
);

  logic [WORD_WIDTH-1:0]         mem_q [N_WORDS][1 << ADDR_WIDTH];
  logic [N_WORDS*WORD_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int w = 0; w < N_WORDS; w++) begin
      if (wr_en && wr_mask[w]) begin
        mem_q[w][wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data_q[w*WORD_WIDTH +: WORD_WIDTH] <= mem_q[w][rd_addr];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hub75_fb_readout.sv
// rtl/hub75_fb_readout.sv - loads one panel row from the frame buffer into a double-buffered line buffer
module hub75_fb_readout
  import hub75_pkg::*;
#(
  parameter int N_BANKS     = DEF_N_BANKS,
  parameter int N_ROWS      = DEF_N_ROWS,
  parameter int N_COLS      = DEF_N_COLS,
  parameter int BITDEPTH    = DEF_BITDEPTH,
  parameter int FB_AW       = DEF_FB_AW,
  parameter int FB_DW       = DEF_FB_DW,
  parameter int FB_DC       = DEF_FB_DC,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LOG_N_ROWS-1:0]        rd_row_addr,
  input  logic                         rd_row_load,
  output logic                         rd_row_rdy,
  input  logic                         rd_row_swap,
  input  logic [LOG_N_COLS-1:0]        rd_col_addr,
  input  logic                         rd_en,
  output logic [N_BANKS*BITDEPTH-1:0]  rd_data,
  output logic                         ctrl_req,
  input  logic                         ctrl_gnt,
  output logic                         ctrl_rel,
  output logic [FB_AW-1:0]             fb_addr,
  output logic                         fb_rden,
  input  logic [FB_DW-1:0]             fb_data
);

  localparam int LAST  = N_COLS * N_BANKS * FB_DC - 1;
  localparam int LB_AW = 1 + LOG_N_COLS;

  rd_state_e               state_q, state_d;
  logic                    rdy_q, rdy_d;
  logic                    req_q, req_d;
  logic                    rel_q, rel_d;
  logic                    sel_q, sel_d;
  logic                    bk_q, bk_d;
  logic [LOG_N_ROWS-1:0]   row_q, row_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    v1_q, v1_d;
  logic [CW-1:0]           cnt1_q, cnt1_d;
  logic [FB_DW*FB_DC-1:0]  asm_q, asm_d;

  int                      dc1, bank1, col1;
  logic                    lb_wr_en;
  logic [LB_AW-1:0]        lb_wr_addr;
  logic [N_BANKS-1:0]      lb_wr_mask;
  logic [BITDEPTH-1:0]     lb_wr_data;

  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    req_d   = req_q;
    rel_d   = 1'b0;
    row_d   = row_q;
    bk_d    = bk_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q ^ rd_row_swap;
    v1_d    = (state_q == RD_RUN);
    cnt1_d  = cnt_q;
    asm_d   = asm_q;

    case (state_q)
      RD_IDLE: begin
        // Latch the back half now so a later swap cannot redirect this load
        if (rd_row_load && rdy_q) begin
          row_d   = rd_row_addr;
          bk_d    = ~sel_q;
          rdy_d   = 1'b0;
          req_d   = 1'b1;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (ctrl_gnt) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = RD_RUN;
        end
      end
      RD_RUN: begin
        if (cnt_q == CW'(LAST)) begin
          cnt_d   = '0;
          rel_d   = 1'b1;
          rdy_d   = 1'b1;
          state_d = RD_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase

    // Delayed counter lines up with fb_data; the last sub-word completes the pixel
    dc1   = int'(cnt1_q) % FB_DC;
    bank1 = (int'(cnt1_q) >> FB_BANK_LSB) % N_BANKS;
    col1  = int'(cnt1_q) >> FB_COL_LSB;
    if (v1_q) begin
      asm_d[FB_DW*dc1 +: FB_DW] = fb_data;
    end
    lb_wr_en   = v1_q && (dc1 == FB_DC - 1);
    lb_wr_addr = {bk_q, LOG_N_COLS'(col1)};
    lb_wr_mask = N_BANKS'(1) << bank1;
    lb_wr_data = asm_d[BITDEPTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RD_IDLE;
      rdy_q   <= 1'b1;
      req_q   <= 1'b0;
      rel_q   <= 1'b0;
      sel_q   <= 1'b0;
      bk_q    <= 1'b0;
      row_q   <= '0;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      cnt1_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      req_q   <= req_d;
      rel_q   <= rel_d;
      sel_q   <= sel_d;
      bk_q    <= bk_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      cnt1_q  <= cnt1_d;
      asm_q   <= asm_d;
    end
  end

  assign rd_row_rdy = rdy_q;
  assign ctrl_req   = req_q;
  assign ctrl_rel   = rel_q;
  assign fb_rden    = (state_q == RD_RUN);
  assign fb_addr    = FB_AW'({row_q, cnt_q});

  hub75_linebuffer #(
    .N_WORDS    (N_BANKS),
    .WORD_WIDTH (BITDEPTH),
    .ADDR_WIDTH (LB_AW)
  ) u_linebuffer (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_wr_addr),
    .wr_mask (lb_wr_mask),
    .wr_data (lb_wr_data),
    .rd_en   (rd_en),
    .rd_addr ({sel_q, rd_col_addr}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_hub75_fb_readout.sv
// tb/tb_hub75_fb_readout.sv - randomized self-checking bench for hub75_fb_readout
module tb_hub75_fb_readout;

  localparam int NB = 2;
  localparam int NC = 64;
  localparam int DC = 2;
  localparam int ROW_WORDS = NB * NC * DC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_row_addr;
  logic        rd_row_load;
  logic        rd_row_rdy;
  logic        rd_row_swap;
  logic [5:0]  rd_col_addr;
  logic        rd_en;
  logic [47:0] rd_data;
  logic        ctrl_req;
  logic        ctrl_gnt;
  logic        ctrl_rel;
  logic [12:0] fb_addr;
  logic        fb_rden;
  logic [15:0] fb_data;

  always #5 clk = ~clk;

  hub75_fb_readout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_row_addr (rd_row_addr),
    .rd_row_load (rd_row_load),
    .rd_row_rdy  (rd_row_rdy),
    .rd_row_swap (rd_row_swap),
    .rd_col_addr (rd_col_addr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .ctrl_req    (ctrl_req),
    .ctrl_gnt    (ctrl_gnt),
    .ctrl_rel    (ctrl_rel),
    .fb_addr     (fb_addr),
    .fb_rden     (fb_rden),
    .fb_data     (fb_data)
  );

  int total = 0;
  int bad   = 0;

  // Frame-buffer model: word = address xor a per-load salt, garbage when not strobed
  logic [15:0] salt = 16'h0;
  always @(posedge clk) fb_data <= fb_rden ? (16'(fb_addr) ^ salt) : 16'($urandom);

  int gnt_delay = 3;
  int req_age   = 0;
  always @(negedge clk) begin
    if (ctrl_req) begin
      req_age++;
      ctrl_gnt = (req_age == gnt_delay + 1);
    end else begin
      req_age  = 0;
      ctrl_gnt = 1'b0;
    end
  end

  int cyc = 0, rden_cnt = 0, req_cnt = 0, rel_cnt = 0, seq_err = 0;
  int first_addr = -1, last_rden_cyc = 0, rel_cyc = 0, rel_rdy = 0, exp_row = 0;
  always @(negedge clk) begin
    cyc++;
    if (fb_rden) begin
      if (rden_cnt == 0) first_addr = int'(fb_addr);
      if (fb_addr !== 13'(exp_row * ROW_WORDS + rden_cnt)) seq_err++;
      rden_cnt++;
      last_rden_cyc = cyc;
    end
    if (ctrl_req) req_cnt++;
    if (ctrl_rel) begin
      rel_cnt++;
      rel_cyc = cyc;
      rel_rdy = int'(rd_row_rdy);
    end
  end

  logic [23:0] exp_lb  [2][NC][NB];
  bit          exp_vld [2][NC];
  int          sel_m = 0;

  function automatic logic [23:0] pix(input int row, input int col, input int bank, input logic [15:0] s);
    int          a0;
    logic [31:0] both;
    a0   = ((row * NC + col) * NB + bank) * DC;
    both = {16'(a0 + 1) ^ s, 16'(a0) ^ s};
    return both[23:0];
  endfunction

  function automatic logic [47:0] exp_word(input int half, input int col);
    return {exp_lb[half][col][1], exp_lb[half][col][0]};
  endfunction

  task automatic clear_mon();
    rden_cnt = 0; req_cnt = 0; rel_cnt = 0; seq_err = 0; first_addr = -1;
  endtask

  task automatic start_load(input int row, input logic [15:0] s, input int gd, output int half);
    @(negedge clk);
    total++;
    if (rd_row_rdy !== 1'b1) begin bad++; $display("FAIL load_rdy got=%b want=1", rd_row_rdy); end
    salt = s; gnt_delay = gd; exp_row = row;
    clear_mon();
    half = 1 - sel_m;
    rd_row_addr = 5'(row); rd_row_load = 1'b1;
    @(negedge clk);
    rd_row_load = 1'b0;
    total++;
    if (rd_row_rdy !== 1'b0 || ctrl_req !== 1'b1) begin
      bad++; $display("FAIL load_accept rdy=%b req=%b want rdy=0 req=1", rd_row_rdy, ctrl_req);
    end
  endtask

  task automatic wait_done(input int row, input logic [15:0] s, input int half, input bit with_reads);
    bit          pend = 0, done = 0;
    logic [47:0] pe = '0;
    int          pc = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (pend) begin
        total++;
        if (rd_data !== pe) begin bad++; $display("FAIL front_during_load col=%0d got=%h want=%h", pc, rd_data, pe); end
      end
      pend = 0;
      if (rel_cnt > 0) done = 1;
      rd_en = with_reads && !done;
      if (with_reads && !done) begin
        pc = $urandom_range(0, NC - 1);
        rd_col_addr = 6'(pc);
        pend = exp_vld[sel_m][pc];
        pe = exp_word(sel_m, pc);
      end
    end
    rd_en = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL load_timeout rel_cnt=%0d want>=1", rel_cnt); end
    repeat (3) @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      for (int b = 0; b < NB; b++) exp_lb[half][c][b] = pix(row, c, b, s);
      exp_vld[half][c] = 1'b1;
    end
  endtask

  task automatic check_stats(input int row, input int gd, input string tag);
    total++;
    if (req_cnt != gd + 1) begin bad++; $display("FAIL %s req_cycles got=%0d want=%0d", tag, req_cnt, gd + 1); end
    total++;
    if (rden_cnt != ROW_WORDS) begin bad++; $display("FAIL %s rden_count got=%0d want=%0d", tag, rden_cnt, ROW_WORDS); end
    total++;
    if (first_addr != row * ROW_WORDS) begin bad++; $display("FAIL %s first_addr got=%0h want=%0h", tag, first_addr, row * ROW_WORDS); end
    total++;
    if (seq_err != 0) begin bad++; $display("FAIL %s addr_sequence errors=%0d want=0", tag, seq_err); end
    total++;
    if (rel_cnt != 1) begin bad++; $display("FAIL %s rel_pulses got=%0d want=1", tag, rel_cnt); end
    total++;
    if (rel_cyc != last_rden_cyc + 1) begin bad++; $display("FAIL %s rel_timing got=%0d want=%0d", tag, rel_cyc, last_rden_cyc + 1); end
    total++;
    if (rel_rdy != 1) begin bad++; $display("FAIL %s rdy_at_rel got=%0d want=1", tag, rel_rdy); end
  endtask

  task automatic do_swap();
    @(negedge clk);
    rd_row_swap = 1'b1;
    @(negedge clk);
    rd_row_swap = 1'b0;
    sel_m = 1 - sel_m;
  endtask

  task automatic read_col(input int col, input string tag);
    bit          v;
    logic [47:0] e;
    @(negedge clk);
    rd_en = 1'b1; rd_col_addr = 6'(col);
    v = exp_vld[sel_m][col];
    e = exp_word(sel_m, col);
    @(negedge clk);
    rd_en = 1'b0;
    total++;
    if (!v || rd_data !== e) begin bad++; $display("FAIL %s col=%0d valid=%0d got=%h want=%h", tag, col, v, rd_data, e); end
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (rd_row_rdy !== 1'b1 || ctrl_req !== 1'b0 || ctrl_rel !== 1'b0 || fb_rden !== 1'b0 || fb_addr !== 13'h0) begin
      bad++;
      $display("FAIL %s rdy=%b req=%b rel=%b rden=%b addr=%h want 1/0/0/0/0", tag, rd_row_rdy, ctrl_req, ctrl_rel, fb_rden, fb_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_row_addr = '0; rd_row_load = 1'b0; rd_row_swap = 1'b0;
    rd_col_addr = '0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("idle_after_reset");
    end
  endtask

  task automatic test_load_basic();
    int h;
    start_load(5, 16'h0000, 3, h);
    wait_done(5, 16'h0000, h, 1'b0);
    check_stats(5, 3, "row5");
    do_swap();
    read_col(17, "row5_col17");
    for (int i = 0; i < 6; i++) read_col($urandom_range(0, NC - 1), "row5_rand");
  endtask

  task automatic test_front_stable();
    int          h, gd;
    logic [15:0] s;
    s = 16'($urandom); gd = $urandom_range(0, 5);
    start_load(3, s, gd, h);
    wait_done(3, s, h, 1'b0);
    check_stats(3, gd, "row3");
    do_swap();
    read_col(0, "row3_col0");
    s = 16'($urandom); gd = $urandom_range(0, 5);
    start_load(9, s, gd, h);
    wait_done(9, s, h, 1'b1);
    check_stats(9, gd, "row9");
    do_swap();
    read_col(NC - 1, "row9_lastcol");
    for (int i = 0; i < 6; i++) read_col($urandom_range(0, NC - 1), "row9_rand");
  endtask

  task automatic test_swap_midload();
    int          h, gd, row, k, req_before;
    logic [15:0] s;
    row = $urandom_range(0, 31); s = 16'($urandom); gd = $urandom_range(0, 5);
    start_load(row, s, gd, h);
    k = 0;
    while (rden_cnt < 50 && k < 1000) begin @(negedge clk); k++; end
    rd_row_swap = 1'b1; rd_row_load = 1'b1; rd_row_addr = 5'((row + 7) % 32);
    @(negedge clk);
    rd_row_swap = 1'b0; rd_row_load = 1'b0;
    sel_m = 1 - sel_m;
    wait_done(row, s, h, 1'b0);
    check_stats(row, gd, "swap_midload");
    req_before = req_cnt;
    repeat (20) @(negedge clk);
    total++;
    if (req_cnt != req_before || rden_cnt != ROW_WORDS) begin
      bad++; $display("FAIL ignored_load req=%0d rden=%0d want req=%0d rden=%0d", req_cnt, rden_cnt, req_before, ROW_WORDS);
    end
    total++;
    if (sel_m != h) begin bad++; $display("FAIL latched_half front=%0d want=%0d", sel_m, h); end
    for (int i = 0; i < 6; i++) read_col($urandom_range(0, NC - 1), "swap_midload_data");
  endtask

  task automatic test_reset_midload();
    int          h, gd, row, k;
    logic [15:0] s;
    row = $urandom_range(0, 31); s = 16'($urandom); gd = $urandom_range(0, 5);
    start_load(row, s, gd, h);
    k = 0;
    while (rden_cnt < 100 && k < 1000) begin @(negedge clk); k++; end
    total++;
    if (fb_rden !== 1'b1) begin bad++; $display("FAIL midload_running rden=%b want=1", fb_rden); end
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sel_m = 0;
    for (int h2 = 0; h2 < 2; h2++) for (int c = 0; c < NC; c++) exp_vld[h2][c] = 1'b0;
    row = $urandom_range(0, 31); s = 16'($urandom); gd = $urandom_range(0, 5);
    start_load(row, s, gd, h);
    wait_done(row, s, h, 1'b0);
    check_stats(row, gd, "after_reset");
    do_swap();
    for (int i = 0; i < 6; i++) read_col($urandom_range(0, NC - 1), "after_reset_data");
  endtask

  initial begin
    for (int h2 = 0; h2 < 2; h2++) for (int c = 0; c < NC; c++) exp_vld[h2][c] = 1'b0;
    ctrl_gnt = 1'b0;
    test_reset();
    test_load_basic();
    test_front_stable();
    test_swap_midload();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_fb_readout.md
Name: hub75_fb_readout

Overview:
Frame-buffer read-out engine for the HUB75 panel path. It is the counterpart of the write-in side.
- On request, it arbitrates for the frame-buffer port and reads one full row (all banks, all columns).
- It reassembles FB_DC sub-words per pixel into a double-buffered line buffer.
- The scan/PWM logic reads pixels from the front half, while the back half is being filled.

Parameters:
N_BANKS, 2, number of panel banks read per row load
N_ROWS, 32, rows per bank
N_COLS, 64, columns per row
BITDEPTH, 24, pixel width
FB_AW, 13, frame-buffer address width
FB_DW, 16, frame-buffer data width
FB_DC, 2, FB words per pixel (FB_DW*FB_DC >= BITDEPTH)
LOG_N_BANKS/LOG_N_ROWS/LOG_N_COLS, derived, $clog2 of the above

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
rd_row_addr  in  LOG_N_ROWS  row to load
rd_row_load  in  1  start loading that row into back buffer
rd_row_rdy  out  1  idle, load accepted
rd_row_swap  in  1  exchange front/back buffers
rd_col_addr  in  LOG_N_COLS  pixel column read from front buffer
rd_en  in  1  front-buffer read enable
rd_data  out  N_BANKS*BITDEPTH  {bankN-1..bank0} pixels, 1 cycle after rd_en
ctrl_req  out  1  arbiter request
ctrl_gnt  in  1  arbiter grant (single-cycle pulse)
ctrl_rel  out  1  arbiter release (single-cycle pulse)
fb_addr  out  FB_AW  {row, col, bank, dc_idx}
fb_rden  out  1  FB read strobe
fb_data  in  FB_DW  FB read data, valid exactly 1 cycle after fb_rden

Behaviour:
- Reset (rst_n low, async): rd_row_rdy=1, ctrl_req=0, ctrl_rel=0, fb_rden=0, fb_addr=0, front-buffer select=0, counter=0, running=0. A reset mid-load aborts the load; back-buffer contents are undefined.
- Buffer select toggles on every rd_row_swap cycle. Front = sel, back = ~sel.
- rd_row_load is honoured only when rd_row_rdy=1. When honoured:
  - Latch the row address and the back-buffer index, so a later swap does not redirect the load.
  - rd_row_rdy drops next cycle and ctrl_req rises next cycle.
  - Load while rdy=0 is ignored.
- ctrl_req stays high until the cycle of ctrl_gnt and drops the following cycle. The gnt cycle sets running next cycle.
- Counter {col, bank, dc} runs 0..N_COLS*N_BANKS*FB_DC-1, incrementing every running cycle (256 reads at defaults).
  - fb_rden = running; fb_addr is combinational from latched row and counter.
  - Port order is col-major, bank, dc (dc fastest).
- Data pipeline: counter/strobe delayed 1 cycle to align with fb_data.
  - dc-th word goes to bits [FB_DW*dc +: FB_DW] of an FB_DW*FB_DC assembly register.
  - On the delayed dc==FB_DC-1 cycle, write the low BITDEPTH bits of {fb_data, assembled lower words} to line buffer address {latched back idx, col}, with mask = one-hot(bank).
  - With FB_DC==1, every beat writes directly.
- Last read cycle clears running next cycle. The final line-buffer write lands 1 cycle after the last fb_rden. On that same cycle, ctrl_rel pulses for 1 cycle and rd_row_rdy returns to 1.
- rd_data: registered line-buffer read at {front idx, rd_col_addr}, 1-cycle latency. It is unaffected by an in-progress load. A swap takes effect for reads issued the cycle after the swap.
- Simultaneous rd_row_swap with a load in progress is allowed; the load finishes into the originally latched half.
- rd_row_load and rd_row_rdy in the same cycle as ctrl_rel: the new load is accepted.

Decomposition:
- Shared package hub75_pkg holds:
  - CS = $clog2(FB_DC)
  - CW = LOG_N_COLS + LOG_N_BANKS + CS
  - the FB address field layout, identical to the write-in side
- Sub-module: the existing hub75_linebuffer, configured as N_WORDS=N_BANKS, WORD_WIDTH=BITDEPTH, ADDR_WIDTH=1+LOG_N_COLS, with a per-word write mask.
- Control, counter and assembly stay in this module.

Test Plan:
- Reset release, then idle 10 cycles -> rd_row_rdy=1, ctrl_req=0, fb_rden=0, ctrl_rel=0 throughout.
- Load row 5, FB model returns addr as data, gnt 3 cycles after req -> ctrl_req high 4 cycles, exactly 256 fb_rden with first fb_addr={5,0,0,0}, ctrl_rel single pulse 1 cycle after the last fb_rden, rdy=1 same cycle.
- After a swap, read col 17 -> rd_data bank1 = {addr(5,17,1,1),addr(5,17,1,0)} truncated to 24 bits, bank0 likewise with bank=0, 1-cycle latency.
- Front-buffer reads of a pre-loaded row 3 during a row-9 load -> rd_data stays row-3 values; after swap, row-9 values.
- rd_row_swap mid-load, plus a second rd_row_load while rdy=0 -> second load ignored (no extra req), data lands in the originally latched half.
- rst_n asserted at read 100 of a load -> all outputs at reset values asynchronously; new load afterwards completes normally with 256 reads.
